// File: rtl/frame_wr_scheduler_pkg.sv
// Shared types, geometry constants and the burst-address helper for the
// frame-buffer write scheduler.
package frame_wr_scheduler_pkg;

   localparam int N_CH   = 3;
   localparam int ADDR_W = 32;
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int OFF_W  = 16;

   localparam logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000;
   localparam logic [ADDR_W-1:0] BURST_BYTES = 32'd256;
   localparam logic [ADDR_W-1:0] BUF_SPAN    = 32'h0080_0000;

   // Element [i] is the burst budget of channel i.
   localparam logic [N_CH-1:0][31:0] FRAME_BURSTS_DEF = {32'd8100, 32'd8100, 32'd32400};

   typedef logic [CH_W-1:0] ch_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WAIT = 2'd2
   } sched_state_e;

   function automatic logic [ADDR_W-1:0] burst_addr(input ch_idx_t ch,
                                                    input logic buf_sel,
                                                    input logic [OFF_W-1:0] off);
      burst_addr = BASE_ADDR
                 + ADDR_W'(ch) * (BUF_SPAN + BUF_SPAN)
                 + (buf_sel ? BUF_SPAN : {ADDR_W{1'b0}})
                 + ADDR_W'(off) * BURST_BYTES;
   endfunction

endpackage

// File: rtl/frame_wr_scheduler_if.sv
// Burst command / completion handshake between the scheduler (master)
// and the AXI write engine (slave).
interface frame_wr_scheduler_if;
   import frame_wr_scheduler_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   ch_idx_t           cmd_ch;
   logic              burst_done;

   modport master (output cmd_valid, output cmd_addr, output cmd_ch,
                   input  cmd_ready, input  burst_done);
   modport slave  (input  cmd_valid, input  cmd_addr, input  cmd_ch,
                   output cmd_ready, output burst_done);
endinterface

// File: rtl/frame_wr_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr,
// wrapping modulo N_CH.
module frame_wr_scheduler_rr_pick
   import frame_wr_scheduler_pkg::*;
(
   input  logic [N_CH-1:0] req,
   input  ch_idx_t         ptr,
   output logic [N_CH-1:0] grant,
   output ch_idx_t         idx,
   output logic            any
);

   always_comb begin
      int      cand_i;
      ch_idx_t cand;
      logic    hit;
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      cand_i = 0;
      cand   = '0;
      hit    = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         cand_i       = int'(ptr) + k;
         cand_i       = (cand_i >= N_CH) ? (cand_i - N_CH) : cand_i;
         cand         = ch_idx_t'(cand_i);
         hit          = !any && req[cand];
         grant[cand]  = grant[cand] | hit;
         idx          = hit ? cand : idx;
         any          = any | hit;
      end
   end

endmodule

// File: rtl/frame_wr_scheduler.sv
// Round-robin, one-burst-at-a-time scheduler sharing the AXI write engine
// between the camera write FIFOs, with ping-pong frame-buffer addressing.
module frame_wr_scheduler
   import frame_wr_scheduler_pkg::*;
#(
   parameter logic [N_CH-1:0][31:0] FRAME_BURSTS = FRAME_BURSTS_DEF
) (
   input  logic                 M_AXI_ACLK,
   input  logic                 M_AXI_ARESET,
   input  logic [N_CH-1:0]      wr_req,
   input  logic [N_CH-1:0]      frame_start,
   frame_wr_scheduler_if.master cmd_if,
   output logic [N_CH-1:0]      wr_grant,
   output logic [N_CH-1:0]      done_buf,
   output logic [N_CH-1:0]      ovf
);

   sched_state_e                state_q, state_d;
   ch_idx_t                     rr_ptr_q, rr_ptr_d;
   logic                        cmd_valid_q, cmd_valid_d;
   logic [ADDR_W-1:0]           cmd_addr_q, cmd_addr_d;
   ch_idx_t                     cmd_ch_q, cmd_ch_d;
   logic [N_CH-1:0]             wr_grant_q, wr_grant_d;
   logic [N_CH-1:0]             done_buf_q, done_buf_d;
   logic [N_CH-1:0]             ovf_q, ovf_d;
   logic [N_CH-1:0]             wr_buf_q, wr_buf_d;
   logic [N_CH-1:0]             pend_fs_q, pend_fs_d;
   logic [N_CH-1:0][OFF_W-1:0]  offset_q, offset_d;

   logic [N_CH-1:0]             elig_s;
   logic [N_CH-1:0]             pick_oh_s;
   ch_idx_t                     pick_idx_s;
   logic                        pick_any_s;

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         elig_s[i] = wr_req[i] && !ovf_q[i] && (32'(offset_q[i]) < FRAME_BURSTS[i]);
      end
   end

   frame_wr_scheduler_rr_pick u_rr_pick (
      .req   (elig_s),
      .ptr   (rr_ptr_q),
      .grant (pick_oh_s),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   always_comb begin
      logic done_s;
      logic owner_s;
      logic fs_apply_s;
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cmd_valid_d = cmd_valid_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_ch_d    = cmd_ch_q;
      wr_grant_d  = wr_grant_q;
      done_buf_d  = done_buf_q;
      ovf_d       = ovf_q;
      wr_buf_d    = wr_buf_q;
      pend_fs_d   = pend_fs_q;
      offset_d    = offset_q;
      owner_s     = 1'b0;
      fs_apply_s  = 1'b0;
      done_s      = (state_q == ST_WAIT) && cmd_if.burst_done;

      // A frame_start hitting the burst owner is deferred to its burst_done.
      for (int i = 0; i < N_CH; i++) begin
         owner_s    = (state_q != ST_IDLE) && (cmd_ch_q == ch_idx_t'(i));
         fs_apply_s = 1'b0;
         if (owner_s && done_s) begin
            if (pend_fs_q[i] || frame_start[i]) begin
               fs_apply_s = 1'b1;
            end else begin
               offset_d[i] = offset_q[i] + OFF_W'(1);
            end
            pend_fs_d[i] = 1'b0;
         end else if (owner_s && frame_start[i]) begin
            pend_fs_d[i] = 1'b1;
         end else begin
            fs_apply_s = frame_start[i];
         end

         if (fs_apply_s) begin
            done_buf_d[i] = wr_buf_q[i];
            wr_buf_d[i]   = ~wr_buf_q[i];
            offset_d[i]   = '0;
            ovf_d[i]      = 1'b0;
         end else if (wr_req[i] && (32'(offset_q[i]) == FRAME_BURSTS[i])) begin
            ovf_d[i] = 1'b1;
         end else begin
            ovf_d[i] = ovf_q[i];
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (pick_any_s) begin
               state_d     = ST_CMD;
               cmd_valid_d = 1'b1;
               cmd_ch_d    = pick_idx_s;
               cmd_addr_d  = burst_addr(pick_idx_s, wr_buf_q[pick_idx_s], offset_q[pick_idx_s]);
               wr_grant_d  = pick_oh_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (cmd_if.cmd_ready) begin
               state_d     = ST_WAIT;
               cmd_valid_d = 1'b0;
               rr_ptr_d    = cmd_ch_q;
            end else begin
               state_d = ST_CMD;
            end
         end
         ST_WAIT: begin
            if (cmd_if.burst_done) begin
               state_d    = ST_IDLE;
               wr_grant_d = '0;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cmd_valid_d = 1'b0;
            wr_grant_d  = '0;
         end
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= ch_idx_t'(N_CH - 1);
         cmd_valid_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_ch_q    <= '0;
         wr_grant_q  <= '0;
         done_buf_q  <= '0;
         ovf_q       <= '0;
         wr_buf_q    <= '0;
         pend_fs_q   <= '0;
         offset_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_ch_q    <= cmd_ch_d;
         wr_grant_q  <= wr_grant_d;
         done_buf_q  <= done_buf_d;
         ovf_q       <= ovf_d;
         wr_buf_q    <= wr_buf_d;
         pend_fs_q   <= pend_fs_d;
         offset_q    <= offset_d;
      end
   end

   assign cmd_if.cmd_valid = cmd_valid_q;
   assign cmd_if.cmd_addr  = cmd_addr_q;
   assign cmd_if.cmd_ch    = cmd_ch_q;
   assign wr_grant         = wr_grant_q;
   assign done_buf         = done_buf_q;
   assign ovf              = ovf_q;

endmodule

// File: tb/tb_frame_wr_scheduler.sv
// Directed bench for frame_wr_scheduler: round-robin order, ping-pong
// addressing, deferred frame_start, overflow and asynchronous reset.
module tb_frame_wr_scheduler;
   import frame_wr_scheduler_pkg::*;

   logic            clk;
   logic            rst;
   logic [N_CH-1:0] wr_req;
   logic [N_CH-1:0] frame_start;
   logic [N_CH-1:0] wr_grant;
   logic [N_CH-1:0] done_buf;
   logic [N_CH-1:0] ovf;

   int n_cmp;
   int n_err;

   frame_wr_scheduler_if bus ();

   frame_wr_scheduler #(
      .FRAME_BURSTS ({32'd4, 32'd8100, 32'd32400})
   ) dut (
      .M_AXI_ACLK   (clk),
      .M_AXI_ARESET (rst),
      .wr_req       (wr_req),
      .frame_start  (frame_start),
      .cmd_if       (bus),
      .wr_grant     (wr_grant),
      .done_buf     (done_buf),
      .ovf          (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cmd(input string tag);
      int k;
      k = 0;
      while (!bus.cmd_valid && k < 20) begin
         step(1);
         k++;
      end
      chk({tag, "_valid"}, 64'(bus.cmd_valid), 64'd1);
   endtask

   task automatic do_burst(input string tag, input int exp_ch, input logic [31:0] exp_addr,
                           input logic [2:0] req_after, input int delay);
      logic [2:0] g_exp;
      g_exp = 3'b001 << exp_ch;
      wait_cmd(tag);
      chk({tag, "_addr"},  64'(bus.cmd_addr), 64'(exp_addr));
      chk({tag, "_ch"},    64'(bus.cmd_ch),   64'(exp_ch));
      chk({tag, "_grant"}, 64'(wr_grant),     64'(g_exp));
      wr_req = req_after;
      step(1);
      chk({tag, "_vld_drop"}, 64'(bus.cmd_valid), 64'd0);
      if (delay > 0) begin
         step(delay);
         chk({tag, "_grant_held"}, 64'(wr_grant), 64'(g_exp));
      end
      bus.burst_done = 1'b1;
      step(1);
      bus.burst_done = 1'b0;
      chk({tag, "_grant_rel"}, 64'(wr_grant), 64'd0);
   endtask

   initial begin
      n_cmp           = 0;
      n_err           = 0;
      rst             = 1'b1;
      wr_req          = 3'b000;
      frame_start     = 3'b000;
      bus.cmd_ready   = 1'b0;
      bus.burst_done  = 1'b0;
      step(2);
      chk("rst_valid", 64'(bus.cmd_valid), 64'd0);
      chk("rst_addr",  64'(bus.cmd_addr),  64'd0);
      chk("rst_ch",    64'(bus.cmd_ch),    64'd0);
      chk("rst_grant", 64'(wr_grant),      64'd0);
      chk("rst_dbuf",  64'(done_buf),      64'd0);
      chk("rst_ovf",   64'(ovf),           64'd0);
      rst = 1'b0;
      step(1);

      // single channel, slow completion
      wr_req        = 3'b001;
      bus.cmd_ready = 1'b1;
      step(1);
      chk("t1_latency", 64'(bus.cmd_valid), 64'd1);
      do_burst("t1a", 0, 32'h1000_0000, 3'b001, 10);
      chk("t1_idle_gap", 64'(bus.cmd_valid), 64'd0);
      do_burst("t1b", 0, 32'h1000_0100, 3'b000, 0);
      step(2);
      chk("t1_no_req", 64'(bus.cmd_valid), 64'd0);

      // round robin from a fresh pointer
      rst = 1'b1;
      step(1);
      rst    = 1'b0;
      wr_req = 3'b111;
      do_burst("t2_c0", 0, 32'h1000_0000, 3'b111, 0);
      do_burst("t2_c1", 1, 32'h1100_0000, 3'b111, 0);
      do_burst("t2_c2", 2, 32'h1200_0000, 3'b111, 0);
      do_burst("t2_c0b", 0, 32'h1000_0100, 3'b000, 0);

      // frame_start on an idle channel
      frame_start = 3'b010;
      step(1);
      frame_start = 3'b000;
      chk("t3_dbuf", 64'(done_buf), 64'd0);
      wr_req = 3'b010;
      do_burst("t3", 1, 32'h1180_0000, 3'b000, 0);
      frame_start = 3'b010;
      step(1);
      frame_start = 3'b000;
      chk("t3_dbuf2", 64'(done_buf), 64'h2);

      // frame_start during the owner's WAIT is deferred
      wr_req = 3'b001;
      wait_cmd("t4");
      chk("t4_addr", 64'(bus.cmd_addr), 64'h1000_0200);
      wr_req = 3'b000;
      step(1);
      frame_start = 3'b001;
      step(1);
      frame_start = 3'b000;
      chk("t4_pend_dbuf", 64'(done_buf), 64'h2);
      chk("t4_pend_vld",  64'(bus.cmd_valid), 64'd0);
      step(2);
      bus.burst_done = 1'b1;
      step(1);
      bus.burst_done = 1'b0;
      chk("t4_dbuf", 64'(done_buf), 64'h2);
      wr_req = 3'b001;
      wait_cmd("t4b");
      chk("t4b_addr", 64'(bus.cmd_addr), 64'h1080_0000);
      wr_req = 3'b000;
      step(2);
      bus.burst_done = 1'b1;
      frame_start    = 3'b001;
      step(1);
      bus.burst_done = 1'b0;
      frame_start    = 3'b000;
      chk("t4_simul_dbuf", 64'(done_buf), 64'h3);
      wr_req = 3'b001;
      do_burst("t4c", 0, 32'h1000_0000, 3'b000, 0);

      // channel 2 budget of 4 bursts
      wr_req = 3'b100;
      do_burst("t5a", 2, 32'h1200_0100, 3'b100, 0);
      do_burst("t5b", 2, 32'h1200_0200, 3'b100, 0);
      do_burst("t5c", 2, 32'h1200_0300, 3'b100, 0);
      step(1);
      chk("t5_ovf_set", 64'(ovf), 64'h4);
      chk("t5_no_cmd",  64'(bus.cmd_valid), 64'd0);
      step(3);
      chk("t5_still_none", 64'(bus.cmd_valid), 64'd0);
      chk("t5_ovf_sticky", 64'(ovf), 64'h4);
      frame_start = 3'b100;
      step(1);
      frame_start = 3'b000;
      chk("t5_ovf_clr", 64'(ovf), 64'd0);
      chk("t5_dbuf",    64'(done_buf), 64'h3);
      do_burst("t5d", 2, 32'h1280_0000, 3'b000, 0);

      // reset while a command is stalled
      wr_req        = 3'b001;
      bus.cmd_ready = 1'b0;
      wait_cmd("t6");
      chk("t6_addr", 64'(bus.cmd_addr), 64'h1000_0100);
      step(2);
      chk("t6_hold_vld",  64'(bus.cmd_valid), 64'd1);
      chk("t6_hold_addr", 64'(bus.cmd_addr),  64'h1000_0100);
      bus.burst_done = 1'b1;
      step(1);
      bus.burst_done = 1'b0;
      chk("t6_done_ign", 64'(bus.cmd_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("t6_rst_vld",   64'(bus.cmd_valid), 64'd0);
      chk("t6_rst_grant", 64'(wr_grant),      64'd0);
      step(2);
      chk("t6_rst_dbuf", 64'(done_buf), 64'd0);
      rst           = 1'b0;
      bus.cmd_ready = 1'b1;
      do_burst("t6b", 0, 32'h1000_0000, 3'b000, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
